// File: rtl/wb_dma_pkg.sv
// rtl/wb_dma_pkg.sv - shared state encoding and default sizes for the Wishbone byte-copy initiator
package wb_dma_pkg;

    localparam int DMA_ADDR_W  = 10;
    localparam int DMA_LEN_W   = 11;
    localparam int DMA_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP_R,
        WR,
        GAP_W,
        DONE
    } state_t;

endpackage

// File: rtl/wb_dma_copy.sv
// rtl/wb_dma_copy.sv - Wishbone byte-copy initiator: one read then one write per byte, idle cycle between accesses
// Optional ACK timeout abort enabled by defining WB_DMA_TIMEOUT_EN.
module wb_dma_copy
    import wb_dma_pkg::*;
#(
    parameter int ADDR_W  = DMA_ADDR_W,
    parameter int LEN_W   = DMA_LEN_W,
    parameter int TIMEOUT = DMA_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] WB_ADRo,
    output logic [7:0]        WB_DATo,
    input  logic [7:0]        WB_DATi,
    output logic              WB_WEo,
    output logic              WB_CYCo,
    output logic              WB_STBo,
    input  logic              WB_ACKi
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [7:0]         byte_q, byte_d;
    logic [ADDR_W-1:0]  adr_d;
    logic [7:0]         dat_d;
    logic               stb_d, we_d, busy_d, done_d, err_d;

`ifdef WB_DMA_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        adr_d   = WB_ADRo;
        dat_d   = WB_DATo;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = RD;
                        src_d   = src;
                        dst_d   = dst;
                        rem_d   = len;
                        adr_d   = src;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            RD: begin
                if (WB_ACKi) begin
                    byte_d  = WB_DATi;
                    state_d = GAP_R;
                end
            end
            GAP_R: begin
                state_d = WR;
                adr_d   = dst_q;
                dat_d   = byte_q;
            end
            WR: begin
                if (WB_ACKi) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        src_d   = src_q + ADDR_W'(1);
                        dst_d   = dst_q + ADDR_W'(1);
                        state_d = GAP_W;
                    end
                end
            end
            GAP_W: begin
                state_d = RD;
                adr_d   = src_q;
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

`ifdef WB_DMA_TIMEOUT_EN
        // Abort on the edge the counter would reach TIMEOUT, so STB drops TIMEOUT cycles after it rose.
        if ((state_q == RD || state_q == WR) && !WB_ACKi && tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
        if (state_d != state_q || WB_ACKi || !(state_q == RD || state_q == WR))
            tmo_d = '0;
        else
            tmo_d = tmo_q + TMO_W'(1);
`endif

        stb_d  = (state_d == RD) || (state_d == WR);
        we_d   = (state_d == WR);
        busy_d = (state_d == RD) || (state_d == GAP_R) || (state_d == WR) || (state_d == GAP_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
            WB_ADRo <= '0;
            WB_DATo <= '0;
            WB_WEo  <= 1'b0;
            WB_CYCo <= 1'b0;
            WB_STBo <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            WB_ADRo <= adr_d;
            WB_DATo <= dat_d;
            WB_WEo  <= we_d;
            WB_CYCo <= stb_d;
            WB_STBo <= stb_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

`ifdef WB_DMA_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`endif

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb/tb_wb_dma_copy.sv - directed and randomized copy checks against a byte-array reference model
module tb_wb_dma_copy;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  src, dst;
    logic [10:0] len;
    logic        busy, done, err;
    logic [9:0]  WB_ADRo;
    logic [7:0]  WB_DATo, WB_DATi;
    logic        WB_WEo, WB_CYCo, WB_STBo, WB_ACKi;

    wb_dma_copy dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err),
        .WB_ADRo(WB_ADRo), .WB_DATo(WB_DATo), .WB_DATi(WB_DATi), .WB_WEo(WB_WEo),
        .WB_CYCo(WB_CYCo), .WB_STBo(WB_STBo), .WB_ACKi(WB_ACKi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem     [1024];
    logic [7:0] ref_mem [1024];
    logic [9:0] rd_q [$];
    int n_chk, n_pass;
    int waits;
    int rises, gap_viol, stab_viol, low_run;
    bit busy_seen, err_seen, prev_stb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Zero-wait responder acks in the cycle after STB; each wait state delays that by one cycle.
    task automatic responder();
        int seen = 0;
        logic [9:0] s_adr;
        logic       s_we;
        logic [7:0] s_dat;
        forever begin
            @(negedge clk);
            if (WB_STBo) begin
                if (!prev_stb) begin
                    rises++;
                    if (rises > 1 && low_run != 1) gap_viol++;
                    seen  = 0;
                    s_adr = WB_ADRo;
                    s_we  = WB_WEo;
                    s_dat = WB_DATo;
                    if (!WB_WEo) rd_q.push_back(WB_ADRo);
                end else if (WB_ADRo !== s_adr || WB_WEo !== s_we || (s_we && WB_DATo !== s_dat)) begin
                    stab_viol++;
                end
                if (WB_CYCo !== 1'b1) stab_viol++;
                seen++;
                if (seen == waits + 2) begin
                    WB_ACKi = 1'b1;
                    if (WB_WEo) mem[WB_ADRo] = WB_DATo;
                end
                low_run = 0;
            end else begin
                WB_ACKi = 1'b0;
                seen    = 0;
                low_run++;
                if (WB_CYCo !== 1'b0 || WB_WEo !== 1'b0) stab_viol++;
            end
            prev_stb = WB_STBo;
            if (busy) busy_seen = 1'b1;
            if (err)  err_seen  = 1'b1;
            WB_DATi = mem[WB_ADRo];
        end
    endtask

    task automatic model_copy(input int s, input int d, input int n);
        for (int i = 0; i < n; i++)
            ref_mem[(d + i) & 1023] = ref_mem[(s + i) & 1023];
    endtask

    function automatic int mem_diff();
        int c = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) c++;
        return c;
    endfunction

    function automatic int rd_order_diff(input int s, input int n);
        int c = 0;
        if (rd_q.size() != n) return 1000 + rd_q.size();
        for (int i = 0; i < n; i++)
            if (rd_q[i] !== 10'((s + i) & 1023)) c++;
        return c;
    endfunction

    task automatic clear_stats();
        rises = 0; gap_viol = 0; stab_viol = 0; busy_seen = 1'b0;
        rd_q.delete();
    endtask

    // Pulses start for one cycle and returns the cycle (counted from the accept edge) in which done was seen.
    task automatic run(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                       input int w, output int done_cyc);
        int cyc;
        @(negedge clk);
        waits = w;
        clear_stats();
        src = s; dst = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        done_cyc = -1;
        while (cyc < 5000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int dc;
        int s, d, n, w;
        bit done_seen;
        rst = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
        WB_ACKi = 1'b0; WB_DATi = '0; waits = 0;
        n_chk = 0; n_pass = 0;
        low_run = 0; prev_stb = 1'b0; err_seen = 1'b0;
        clear_stats();
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        fork
            responder();
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, WB_STBo, WB_CYCo, WB_WEo, WB_ADRo, WB_DATo}, 64'd0);
        rst = 1'b1;

        // Basic 4-byte copy
        for (int i = 0; i < 4; i++) begin
            mem[16 + i]     = 8'(8'h11 * (i + 1));
            ref_mem[16 + i] = 8'(8'h11 * (i + 1));
        end
        run(10'h010, 10'h200, 11'd4, 0, dc);
        model_copy(10'h010, 10'h200, 4);
        check("t1_done_cycle", dc, 25);
        check("t1_byte0", mem[10'h200], 8'h11);
        check("t1_byte1", mem[10'h201], 8'h22);
        check("t1_byte2", mem[10'h202], 8'h33);
        check("t1_byte3", mem[10'h203], 8'h44);
        check("t1_stb_rises", rises, 8);
        check("t1_gap_viol", gap_viol, 0);
        @(negedge clk);
        check("t1_done_pulse_len", {done, busy}, 2'b00);
        check("t1_mem", mem_diff(), 0);

        // Zero length
        run(10'h055, 10'h0AA, 11'd0, 0, dc);
        check("len0_done_cycle", dc, 1);
        check("len0_stb_rises", rises, 0);
        check("len0_busy_seen", busy_seen, 1'b0);
        check("len0_mem", mem_diff(), 0);

        // Address wrap
        run(10'h3FE, 10'h100, 11'd4, 0, dc);
        model_copy(10'h3FE, 10'h100, 4);
        check("wrap_rd_order", rd_order_diff(10'h3FE, 4), 0);
        check("wrap_done_cycle", dc, 25);
        check("wrap_mem", mem_diff(), 0);

        // Three wait states per access
        run(10'h020, 10'h300, 11'd2, 3, dc);
        model_copy(10'h020, 10'h300, 2);
        check("wait_mem", mem_diff(), 0);
        check("wait_stability", stab_viol, 0);
        check("wait_stb_rises", rises, 4);
        check("wait_gaps", gap_viol, 0);
        check("wait_done_cycle", dc, 2 * (2 * 3 + 6) + 1);

        // Randomized copies, overlap allowed
        for (int k = 0; k < 6; k++) begin
            s = int'($urandom_range(0, 1023));
            d = int'($urandom_range(0, 1023));
            n = int'($urandom_range(1, 24));
            w = int'($urandom_range(0, 2));
            run(10'(s), 10'(d), 11'(n), w, dc);
            model_copy(s, d, n);
            check($sformatf("rand%0d_mem", k), mem_diff(), 0);
            check($sformatf("rand%0d_done_cycle", k), dc, n * (2 * w + 6) + 1);
            check($sformatf("rand%0d_rd_order", k), rd_order_diff(s, n), 0);
            check($sformatf("rand%0d_bus", k), {stab_viol, gap_viol}, 64'd0);
        end

        // Second start mid-transfer is ignored, then reset during the second byte
        @(negedge clk);
        waits = 0;
        clear_stats();
        src = 10'h140; dst = 10'h240; len = 11'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        src = 10'h2AA; dst = 10'h0AA; len = 11'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_busy", busy, 1'b1);
        repeat (4) @(negedge clk);
        check("rst_before_stb", WB_STBo, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_async_outputs", {WB_STBo, WB_CYCo, WB_WEo, busy, done}, 5'b0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("rst_no_done", done_seen, 1'b0);
        check("rst_rd_order", rd_order_diff(10'h140, 2), 0);
        model_copy(10'h140, 10'h240, 1);
        check("rst_partial_mem", mem_diff(), 0);

        run(10'h2F0, 10'h050, 11'd5, 1, dc);
        model_copy(10'h2F0, 10'h050, 5);
        check("after_rst_mem", mem_diff(), 0);
        check("after_rst_done_cycle", dc, 5 * 8 + 1);
        check("err_never", err_seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
